// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file for the micro-riscv core.
// Provides combinational reads with write-first bypass, highest-index-wins
// write arbitration, asynchronous clear, and a per-register busy scoreboard.
// Register 0 has no storage. Ids at or above NUM_REGS never match a register.
module gpr_file_mp #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ID_BITS  = $clog2(NUM_REGS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_RD*ID_BITS-1:0] rd_id,
   output logic [NUM_RD*XLEN-1:0]    rd_val,
   output logic [NUM_RD-1:0]         rd_busy,
   input  logic [NUM_WR-1:0]         wr_en,
   input  logic [NUM_WR*ID_BITS-1:0] wr_id,
   input  logic [NUM_WR*XLEN-1:0]    wr_val,
   input  logic                      alloc_en,
   input  logic [ID_BITS-1:0]        alloc_id,
   output logic                      busy_any
);

   logic [XLEN-1:0]     regs    [1:NUM_REGS-1];
   logic [NUM_REGS-1:1] busy;
   logic [NUM_REGS-1:1] wr_hit;
   logic [XLEN-1:0]     wr_data [1:NUM_REGS-1];
   logic [NUM_REGS-1:1] alloc_hit;

   // Per-register write decode; later ports overwrite earlier ones so the
   // highest-index enabled port wins. Gated by rst so nothing bypasses
   // through to the read ports while the file is held in reset.
   always_comb begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         wr_hit[r]    = 1'b0;
         wr_data[r]   = '0;
         alloc_hit[r] = alloc_en && (alloc_id == ID_BITS'(r));
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (!rst && wr_en[w] && (wr_id[w*ID_BITS +: ID_BITS] == ID_BITS'(r))) begin
               wr_hit[r]  = 1'b1;
               wr_data[r] = wr_val[w*XLEN +: XLEN];
            end
         end
      end
   end

   // Register storage: commit decoded writes on the rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 1; r < NUM_REGS; r++) regs[r] <= '0;
      end else begin
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (wr_hit[r]) regs[r] <= wr_data[r];
         end
      end
   end

   // Scoreboard: alloc names a newer producer, so it beats a same-cycle write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (alloc_hit[r])    busy[r] <= 1'b1;
            else if (wr_hit[r])  busy[r] <= 1'b0;
         end
      end
   end

   // Read ports: id 0 and out-of-range ids fall through to zero / not busy.
   always_comb begin
      rd_val  = '0;
      rd_busy = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (rd_id[p*ID_BITS +: ID_BITS] == ID_BITS'(r)) begin
               rd_val[p*XLEN +: XLEN] = wr_hit[r] ? wr_data[r] : regs[r];
               rd_busy[p]             = busy[r] & ~wr_hit[r];
            end
         end
      end
   end

   // Drain indicator reflects registered busy state only.
   always_comb begin
      busy_any = |busy;
   end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed self-checking bench for gpr_file_mp (default parameters).
module tb_gpr_file_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  rd_id;
   logic [63:0] rd_val;
   logic [1:0]  rd_busy;
   logic [1:0]  wr_en;
   logic [9:0]  wr_id;
   logic [63:0] wr_val;
   logic        alloc_en;
   logic [4:0]  alloc_id;
   logic        busy_any;

   int errors = 0;
   int checks = 0;

   gpr_file_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
      .clk(clk), .rst(rst), .rd_id(rd_id), .rd_val(rd_val), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_id(wr_id), .wr_val(wr_val),
      .alloc_en(alloc_en), .alloc_id(alloc_id), .busy_any(busy_any)
   );

   always #5 clk = ~clk;

   task automatic idle();
      wr_en    = 2'b00;
      wr_id    = '0;
      wr_val   = '0;
      alloc_en = 1'b0;
      alloc_id = '0;
   endtask

   task automatic test_reset();
      idle();
      rd_id = '0;
      rst   = 1'b1;
      #1;
      for (int i = 1; i < 32; i++) begin
         rd_id = {5'(32 - i), 5'(i)};
         #1;
         checks++; if (rd_val !== 64'h0) begin errors++; $display("FAIL reset_val id=%0d: got %h want 0", i, rd_val); end
         checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy id=%0d: got %b want 00", i, rd_busy); end
         checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL reset_busy_any: got %b want 0", busy_any); end
      end
      @(negedge clk);
      rst   = 1'b0;
      rd_id = {5'd31, 5'd5};
      #1;
      checks++; if (rd_val !== 64'h0) begin errors++; $display("FAIL post_reset_read: got %h want 0", rd_val); end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      wr_en = 2'b01; wr_id = {5'd0, 5'd5}; wr_val = {32'h0, 32'hDEADBEEF};
      rd_id = {5'd0, 5'd0};
      @(negedge clk);
      idle();
      rd_id = {5'd0, 5'd5};
      #1;
      checks++; if (rd_val[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL x5_readback: got %h want deadbeef", rd_val[31:0]); end
      checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL x5_not_busy: got %b want 0", rd_busy[0]); end
      // write to x0 via port 1; must neither bypass nor store
      wr_en = 2'b10; wr_id = {5'd0, 5'd0}; wr_val = {32'h1234, 32'h0};
      rd_id = {5'd0, 5'd0};
      #1;
      checks++; if (rd_val !== 64'h0) begin errors++; $display("FAIL x0_bypass: got %h want 0", rd_val); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (rd_val !== 64'h0) begin errors++; $display("FAIL x0_read: got %h want 0", rd_val); end
   endtask

   task automatic test_bypass_priority();
      @(negedge clk);
      wr_en = 2'b11; wr_id = {5'd7, 5'd7}; wr_val = {32'h22, 32'h11};
      rd_id = {5'd7, 5'd7};
      #1;
      checks++; if (rd_val[63:32] !== 32'h22) begin errors++; $display("FAIL bypass_p1: got %h want 22", rd_val[63:32]); end
      checks++; if (rd_val[31:0] !== 32'h22) begin errors++; $display("FAIL bypass_p0: got %h want 22", rd_val[31:0]); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (rd_val[63:32] !== 32'h22) begin errors++; $display("FAIL x7_stored: got %h want 22", rd_val[63:32]); end
      // only port 0 targets x7 this time; port 1 writes x10
      wr_en = 2'b11; wr_id = {5'd10, 5'd7}; wr_val = {32'hA0, 32'h44};
      rd_id = {5'd10, 5'd7};
      #1;
      checks++; if (rd_val !== {32'hA0, 32'h44}) begin errors++; $display("FAIL bypass_split: got %h want 000000a000000044", rd_val); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (rd_val !== {32'hA0, 32'h44}) begin errors++; $display("FAIL split_stored: got %h want 000000a000000044", rd_val); end
   endtask

   task automatic test_scoreboard();
      // alloc of x0 is ignored
      @(negedge clk);
      alloc_en = 1'b1; alloc_id = 5'd0; rd_id = {5'd0, 5'd0};
      @(negedge clk);
      idle();
      #1;
      checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL alloc_x0: got %b want 0", busy_any); end
      // alloc x9: invisible this cycle, busy next
      alloc_en = 1'b1; alloc_id = 5'd9; rd_id = {5'd9, 5'd9};
      #1;
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL alloc_same_cycle: got %b want 00", rd_busy); end
      checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL alloc_same_any: got %b want 0", busy_any); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL x9_busy: got %b want 11", rd_busy); end
      checks++; if (busy_any !== 1'b1) begin errors++; $display("FAIL x9_busy_any: got %b want 1", busy_any); end
      // write x9 clears rd_busy combinationally
      wr_en = 2'b10; wr_id = {5'd9, 5'd0}; wr_val = {32'h55, 32'h0};
      #1;
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL wr_mask_busy: got %b want 00", rd_busy); end
      checks++; if (rd_val[31:0] !== 32'h55) begin errors++; $display("FAIL wr_bypass_x9: got %h want 55", rd_val[31:0]); end
      checks++; if (busy_any !== 1'b1) begin errors++; $display("FAIL any_no_bypass: got %b want 1", busy_any); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL x9_cleared: got %b want 0", busy_any); end
      checks++; if (rd_val[63:32] !== 32'h55) begin errors++; $display("FAIL x9_stored: got %h want 55", rd_val[63:32]); end
      // alloc and write in the same cycle: alloc wins
      alloc_en = 1'b1; alloc_id = 5'd9;
      wr_en = 2'b01; wr_id = {5'd0, 5'd9}; wr_val = {32'h0, 32'h66};
      @(negedge clk);
      idle();
      #1;
      checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL alloc_wins: got %b want 11", rd_busy); end
      checks++; if (rd_val[31:0] !== 32'h66) begin errors++; $display("FAIL alloc_wr_data: got %h want 66", rd_val[31:0]); end
      // second alloc keeps it busy
      alloc_en = 1'b1; alloc_id = 5'd9;
      @(negedge clk);
      idle();
      #1;
      checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL realloc_busy: got %b want 1", rd_busy[0]); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      alloc_en = 1'b1; alloc_id = 5'd3;
      @(negedge clk);
      idle();
      rd_id = {5'd5, 5'd3};
      #1;
      checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL x3_busy: got %b want 1", rd_busy[0]); end
      wr_en = 2'b01; wr_id = {5'd0, 5'd3}; wr_val = {32'h0, 32'hAB};
      #1;
      checks++; if (rd_val[31:0] !== 32'hAB) begin errors++; $display("FAIL x3_bypass: got %h want ab", rd_val[31:0]); end
      rst = 1'b1;
      #1;
      checks++; if (rd_val !== 64'h0) begin errors++; $display("FAIL rst_mid_val: got %h want 0", rd_val); end
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL rst_mid_busy: got %b want 00", rd_busy); end
      checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL rst_mid_any: got %b want 0", busy_any); end
      @(posedge clk);
      #1;
      idle();
      rst = 1'b0;
      #1;
      checks++; if (rd_val !== 64'h0) begin errors++; $display("FAIL write_dropped: got %h want 0", rd_val); end
      checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL busy_dropped: got %b want 00", rd_busy); end
      rd_id = {5'd9, 5'd7};
      #1;
      checks++; if (rd_val !== 64'h0) begin errors++; $display("FAIL regs_cleared: got %h want 0", rd_val); end
      checks++; if (busy_any !== 1'b0) begin errors++; $display("FAIL any_cleared: got %b want 0", busy_any); end
   endtask

   initial begin
      idle();
      rd_id = '0;
      test_reset();
      test_write_read();
      test_bypass_priority();
      test_scoreboard();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
